// File: rtl/k4n8_cfg_chain_loader.sv
// K4N8 configuration loader: assembles a byte stream into CHAIN_LEN-bit frames and shifts them LSB-first into the scan chain.
// Optional trailing CRC-8 image check is enabled by defining CFG_CRC_CHECK_EN.
module k4n8_cfg_chain_loader #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CHAIN_LEN  = 16,
  parameter int unsigned NUM_FRAMES = 8,
  localparam int unsigned FIDX_W    = $clog2(NUM_FRAMES + 1)
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sc_d,
  output logic              sc_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [FIDX_W-1:0] frame_idx
);

  localparam int unsigned NUM_SLOTS = CHAIN_LEN / DATA_W;
  localparam int unsigned SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned BIT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_FINISH, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [CHAIN_LEN-1:0]  buf_q, buf_d;
  logic [BIT_W-1:0]      bit_q, bit_d, slot_base;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [FIDX_W-1:0]     frame_d;
  logic                  in_ready_d, sc_d_d, sc_en_d, busy_d, done_d, err_d;
  logic                  hs;

`ifdef CFG_CRC_CHECK_EN
  logic [7:0] crc_q, crc_d;

  // CRC-8, poly 0x07, MSB-first, no reflection, no final XOR
  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [DATA_W-1:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction
`endif

  assign hs        = in_valid & in_ready;
  assign slot_base = BIT_W'(slot_q) * BIT_W'(DATA_W);

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    frame_d = frame_idx;
    err_d   = err;
`ifdef CFG_CRC_CHECK_EN
    crc_d   = crc_q;
`endif

    if (abort) begin
      // abort also wins over start while idle; the partial frame is dropped
      state_d = S_IDLE;
      buf_d   = '0;
      bit_d   = '0;
      slot_d  = '0;
`ifdef CFG_CRC_CHECK_EN
      crc_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            err_d   = 1'b0;
            frame_d = '0;
            slot_d  = '0;
            bit_d   = '0;
`ifdef CFG_CRC_CHECK_EN
            crc_d   = '0;
`endif
          end
        end
        S_LOAD: begin
          if (hs) begin
            buf_d[slot_base +: DATA_W] = in_data;
`ifdef CFG_CRC_CHECK_EN
            crc_d = crc8_upd(crc_q, in_data);
`endif
            if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
              slot_d  = '0;
              bit_d   = '0;
              state_d = S_SHIFT;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
        S_SHIFT: begin
          buf_d = buf_q >> 1;
          if (bit_q == BIT_W'(CHAIN_LEN - 1)) begin
            bit_d   = '0;
            frame_d = frame_idx + FIDX_W'(1);
            state_d = (frame_d < FIDX_W'(NUM_FRAMES)) ? S_LOAD : S_FINISH;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
        S_FINISH: begin
`ifdef CFG_CRC_CHECK_EN
          if (hs) state_d = (in_data == DATA_W'(crc_q)) ? S_DONE : S_ERROR;
`else
          state_d = S_IDLE;
`endif
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // outputs are registered copies of what the next state implies
    sc_en_d = (state_d == S_SHIFT);
    sc_d_d  = sc_en_d & buf_d[0];
`ifdef CFG_CRC_CHECK_EN
    in_ready_d = (state_d == S_LOAD) || (state_d == S_FINISH);
    busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_FINISH);
    done_d     = (state_d == S_DONE);
    if (state_d == S_ERROR) err_d = 1'b1;
`else
    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT);
    done_d     = (state_d == S_FINISH);
`endif
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      bit_q     <= '0;
      slot_q    <= '0;
      frame_idx <= '0;
      in_ready  <= 1'b0;
      sc_en     <= 1'b0;
      sc_d      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      bit_q     <= bit_d;
      slot_q    <= slot_d;
      frame_idx <= frame_d;
      in_ready  <= in_ready_d;
      sc_en     <= sc_en_d;
      sc_d      <= sc_d_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

`ifdef CFG_CRC_CHECK_EN
  always_ff @(posedge C or negedge R) begin
    if (!R) crc_q <= '0;
    else    crc_q <= crc_d;
  end
`endif

endmodule

// File: tb/tb_k4n8_cfg_chain_loader.sv
// Scoreboard bench for k4n8_cfg_chain_loader: expected scan bits are queued as bytes are accepted and popped on sc_en.
module tb_k4n8_cfg_chain_loader;

  localparam int unsigned DW  = 8;
  localparam int unsigned CL  = 16;
  localparam int unsigned NF  = 8;
  localparam int unsigned FW  = $clog2(NF + 1);
  localparam int unsigned BPF = CL / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, sc_d, sc_en, busy, done, err;
  logic [FW-1:0] frame_idx;

  int   n_checks = 0, n_fail = 0;
  int   sc_cnt = 0, burst_cnt = 0, done_cnt = 0;
  bit   prev_en = 1'b0;
  logic [7:0] crc_m = 8'h00;
  bit   exp_q[$];

  k4n8_cfg_chain_loader #(.DATA_W(DW), .CHAIN_LEN(CL), .NUM_FRAMES(NF)) dut (
    .C(clk), .R(rst_n), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .sc_d(sc_d), .sc_en(sc_en),
    .busy(busy), .done(done), .err(err), .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Byte-wise reference CRC-8 (poly 0x07)
  task automatic crc_add(input logic [7:0] b);
    logic [7:0] c;
    c = crc_m ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    crc_m = c;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit is_data);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    in_valid = 1'b0;
    chk("handshake", 32'(ok), 1);
    if (ok && is_data) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      crc_add(b);
    end
  endtask

  // Scan-chain monitor: pops expected bits, tracks bursts and done pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (sc_en) begin
        sc_cnt++;
        if (!prev_en) begin
          burst_cnt++;
          chk("fidx_at_burst", 32'(frame_idx), 32'(burst_cnt - 1));
        end
        if (exp_q.size() == 0) chk("sc_extra", 1, 0);
        else                   chk("sc_d", 32'(sc_d), 32'(exp_q.pop_front()));
      end else begin
        chk("sc_d_idle", 32'(sc_d), 0);
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 32'(busy), 0);
      end
      prev_en = sc_en;
    end
  end

  task automatic run_image(input bit gap, input bit first_fixed, input bit pulse, input bit bad_crc);
    logic [7:0] b;
    bit seen;
    burst_cnt = 0;
    sc_cnt    = 0;
    done_cnt  = 0;
    crc_m     = 8'h00;
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    chk("fidx_after_start", 32'(frame_idx), 0);
    chk("err_after_start", 32'(err), 0);
    for (int f = 0; f < int'(NF); f++) begin
      for (int k = 0; k < int'(BPF); k++) begin
        b = 8'($urandom);
        if (first_fixed && f == 0) b = (k == 0) ? 8'hA5 : 8'h3C;
        if (pulse && f == 3 && k == 1) pulse_start();
        send_byte(b, gap, 1'b1);
      end
      if (first_fixed && f == 0) begin
        chk("first_sc_en_latency", 32'(sc_en), 1);
        chk("ready_low_in_shift", 32'(in_ready), 0);
        repeat (CL - 1) step();
        chk("last_shift_cycle", 32'(sc_en), 1);
        step();
        chk("sc_en_after_burst", 32'(sc_en), 0);
        chk("ready_after_burst", 32'(in_ready), 1);
        chk("fidx_after_frame0", 32'(frame_idx), 1);
      end
      if (pulse && f == 3) begin
        pulse_start();
        chk("start_ign_sc_en", 32'(sc_en), 1);
        chk("start_ign_fidx", 32'(frame_idx), 3);
      end
    end
`ifdef CFG_CRC_CHECK_EN
    send_byte(bad_crc ? ~crc_m : crc_m, 1'b0, 1'b0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bad_crc ? err : done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("image_end_seen", 32'(seen), 1);
    step();
    if (bad_crc) begin
      chk("no_done_on_bad_crc", 32'(done_cnt), 0);
      chk("err_sticky", 32'(err), 1);
    end else begin
      chk("done_once", 32'(done_cnt), 1);
      chk("done_width", 32'(done), 0);
      chk("err_clear", 32'(err), 0);
    end
    chk("busy_end", 32'(busy), 0);
    chk("fidx_end", 32'(frame_idx), NF);
    chk("sc_total", 32'(sc_cnt), NF * CL);
    chk("bursts", 32'(burst_cnt), NF);
    chk("exp_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_sc_en", 32'(sc_en), 0);
    chk("rst_sc_d", 32'(sc_d), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fidx", 32'(frame_idx), 0);
    rst_n = 1'b1;
    repeat (2) step();

    run_image(1'b1, 1'b1, 1'b0, 1'b0);
    run_image(1'b0, 1'b0, 1'b1, 1'b0);

    // abort on the 5th shift cycle of frame 2
    burst_cnt = 0;
    sc_cnt    = 0;
    done_cnt  = 0;
    exp_q.delete();
    pulse_start();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < int'(BPF); k++) send_byte(8'($urandom), 1'b0, 1'b1);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_sc_en", 32'(sc_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(in_ready), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bits_left", 32'(exp_q.size()), CL - 5);
    chk("abort_sc_count", 32'(sc_cnt), 2 * CL + 5);
    exp_q.delete();
    repeat (3) step();
    chk("abort_no_done", 32'(done_cnt), 0);
    chk("abort_stays_idle", 32'(busy), 0);
    run_image(1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a shift burst
    burst_cnt = 0;
    pulse_start();
    for (int k = 0; k < int'(BPF); k++) send_byte(8'($urandom), 1'b0, 1'b1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sc_en", 32'(sc_en), 0);
    chk("arst_sc_d", 32'(sc_d), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(in_ready), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_fidx", 32'(frame_idx), 0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ready", 32'(in_ready), 0);
    chk("post_rst_sc_en", 32'(sc_en), 0);

`ifdef CFG_CRC_CHECK_EN
    run_image(1'b0, 1'b0, 1'b0, 1'b1);
    run_image(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
